// File: rtl/ahb_param_arbiter_pkg.sv
// Shared AHB encodings, arbitration-mode constants and burst-length decode
// for the parametrised AHB arbiter.
package ahb_param_arbiter_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_BUSY   = 2'b01,
      HT_NONSEQ = 2'b10,
      HT_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HB_SINGLE = 3'b000,
      HB_INCR   = 3'b001,
      HB_WRAP4  = 3'b010,
      HB_INCR4  = 3'b011,
      HB_WRAP8  = 3'b100,
      HB_INCR8  = 3'b101,
      HB_WRAP16 = 3'b110,
      HB_INCR16 = 3'b111
   } hburst_e;

   typedef enum logic [1:0] {
      HR_OKAY  = 2'b00,
      HR_ERROR = 2'b01,
      HR_RETRY = 2'b10,
      HR_SPLIT = 2'b11
   } hresp_e;

   localparam logic ARB_FIXED = 1'b0;
   localparam logic ARB_RR    = 1'b1;

   localparam int unsigned IDX_W = 4;
   localparam int unsigned CNT_W = 4;

   // Remaining beats after the NONSEQ; undefined-length bursts count as single.
   function automatic logic [CNT_W-1:0] burst_beats(input hburst_e b);
      logic [CNT_W-1:0] n;
      unique case (b)
         HB_WRAP4,  HB_INCR4:  n = 4'd3;
         HB_WRAP8,  HB_INCR8:  n = 4'd7;
         HB_WRAP16, HB_INCR16: n = 4'd15;
         default:              n = '0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/ahb_arb_select.sv
// Combinational winner selection: fixed priority (lowest index) or
// round-robin starting after the pointer, with default-master fallback.
module ahb_arb_select
   import ahb_param_arbiter_pkg::*;
#(
   parameter int unsigned N_MASTERS  = 4,
   parameter int unsigned DEF_MASTER = 0
) (
   input  logic [N_MASTERS-1:0] req_i,
   input  logic [IDX_W-1:0]     ptr_i,
   input  logic                 mode_i,
   output logic [N_MASTERS-1:0] win_oh_o,
   output logic [IDX_W-1:0]     win_idx_o,
   output logic                 any_req_o
);

   logic [N_MASTERS-1:0] upper_req;
   logic                 found_hi;
   logic                 found_all;
   logic [IDX_W-1:0]     idx_hi;
   logic [IDX_W-1:0]     idx_all;
   logic [IDX_W-1:0]     win_idx;

   // Round-robin is split into "above the pointer" and "anywhere"; the wrap
   // case falls back to plain lowest-index search over all requesters.
   always_comb begin
      upper_req = '0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         upper_req[i] = req_i[i] & (i > 32'(ptr_i));
      end

      found_hi = 1'b0;
      idx_hi   = '0;
      for (int unsigned i = N_MASTERS; i > 0; i--) begin
         if (upper_req[i-1]) begin
            found_hi = 1'b1;
            idx_hi   = IDX_W'(i-1);
         end
      end

      found_all = 1'b0;
      idx_all   = '0;
      for (int unsigned i = N_MASTERS; i > 0; i--) begin
         if (req_i[i-1]) begin
            found_all = 1'b1;
            idx_all   = IDX_W'(i-1);
         end
      end

      win_idx = IDX_W'(DEF_MASTER);
      if ((mode_i == ARB_RR) && found_hi) begin
         win_idx = idx_hi;
      end else if (found_all) begin
         win_idx = idx_all;
      end

      win_oh_o = '0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         win_oh_o[i] = (32'(win_idx) == i);
      end
   end

   assign win_idx_o = win_idx;
   assign any_req_o = found_all;

endmodule

// File: rtl/ahb_param_arbiter.sv
// Parametrised AHB-Lite/AHB2 arbiter: burst-protected, lock-aware grant
// with default-master parking and one-cycle ownership hand-over.
module ahb_param_arbiter
   import ahb_param_arbiter_pkg::*;
#(
   parameter int unsigned N_MASTERS  = 4,
   parameter int unsigned ARB_MODE   = 1,
   parameter int unsigned DEF_MASTER = 0
) (
   input  logic                 hclk,
   input  logic                 hreset,
   input  logic [N_MASTERS-1:0] hbusreq,
   input  logic [N_MASTERS-1:0] hlock,
   input  logic [1:0]           htrans,
   input  logic [2:0]           hburst,
   input  logic                 hready,
   input  logic [1:0]           hresp,
   output logic [N_MASTERS-1:0] hgrant,
   output logic [IDX_W-1:0]     hmaster,
   output logic                 hmastlock
);

   localparam logic MODE = (ARB_MODE == 32'd1) ? ARB_RR : ARB_FIXED;

   htrans_e trans;
   hburst_e burst;
   hresp_e  resp;

   assign trans = htrans_e'(htrans);
   assign burst = hburst_e'(hburst);
   assign resp  = hresp_e'(hresp);

   logic [N_MASTERS-1:0] hgrant_q,    hgrant_d;
   logic [IDX_W-1:0]     hmaster_q,   hmaster_d;
   logic                 hmastlock_q, hmastlock_d;
   logic [CNT_W-1:0]     cnt_q,       cnt_d;
   logic [IDX_W-1:0]     ptr_q,       ptr_d;

   logic [N_MASTERS-1:0] win_oh;
   logic [IDX_W-1:0]     win_idx;
   logic                 any_req;

   logic [IDX_W-1:0]     grant_idx;
   logic                 lock_owner;
   logic                 lock_grant;
   logic                 burst_end;
   logic                 arb_ok;

   ahb_arb_select #(
      .N_MASTERS  (N_MASTERS),
      .DEF_MASTER (DEF_MASTER)
   ) u_select (
      .req_i     (hbusreq),
      .ptr_i     (ptr_q),
      .mode_i    (MODE),
      .win_oh_o  (win_oh),
      .win_idx_o (win_idx),
      .any_req_o (any_req)
   );

   always_comb begin
      grant_idx  = '0;
      lock_owner = 1'b0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         if (hgrant_q[i]) begin
            grant_idx = IDX_W'(i);
         end
         if (32'(hmaster_q) == i) begin
            lock_owner = hlock[i];
         end
      end
      lock_grant = |(hlock & hgrant_q);
   end

   // A NONSEQ is judged on the length it is about to load, everything else
   // on the running count, so single transfers can hand over immediately.
   always_comb begin
      if (trans == HT_NONSEQ) begin
         burst_end = (burst_beats(burst) == '0);
      end else begin
         burst_end = (cnt_q <= 4'd1);
      end
      arb_ok = hready && !lock_owner &&
               (burst_end || (trans == HT_IDLE) || (resp != HR_OKAY));
   end

   always_comb begin
      cnt_d = cnt_q;
      if (resp != HR_OKAY) begin
         cnt_d = '0;
      end else if (hready && (trans == HT_NONSEQ)) begin
         cnt_d = burst_beats(burst);
      end else if (hready && (trans == HT_SEQ) && (cnt_q != '0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_comb begin
      hgrant_d    = hgrant_q;
      ptr_d       = ptr_q;
      hmaster_d   = hmaster_q;
      hmastlock_d = hmastlock_q;
      if (arb_ok) begin
         hgrant_d = win_oh;
         if (any_req) begin
            ptr_d = win_idx;
         end
      end
      if (hready) begin
         hmaster_d   = grant_idx;
         hmastlock_d = lock_grant;
      end
   end

   always_ff @(posedge hclk or negedge hreset) begin
      if (!hreset) begin
         hgrant_q    <= N_MASTERS'(1) << DEF_MASTER;
         hmaster_q   <= IDX_W'(DEF_MASTER);
         hmastlock_q <= 1'b0;
         cnt_q       <= '0;
         ptr_q       <= IDX_W'(DEF_MASTER);
      end else begin
         hgrant_q    <= hgrant_d;
         hmaster_q   <= hmaster_d;
         hmastlock_q <= hmastlock_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
      end
   end

   assign hgrant    = hgrant_q;
   assign hmaster   = hmaster_q;
   assign hmastlock = hmastlock_q;

endmodule
